// File: rtl/keyboard_sync_fifo_flex_if.sv
// Bus bundle for keyboard_sync_fifo_flex: control, thresholds, write/read ports and status.
// The master drives requests; the slave (the FIFO) drives data and status.
interface keyboard_sync_fifo_flex_if #(
  parameter int N   = 16,
  parameter int D_N = 4
);
  logic           iREMOVE;
  logic           iERR_CLEAR;
  logic [D_N:0]   iAF_THRESH;
  logic [D_N:0]   iAE_THRESH;
  logic           iWR_EN;
  logic [N-1:0]   iWR_DATA;
  logic           iRD_EN;
  logic [N-1:0]   oRD_DATA;
  logic [D_N:0]   oCOUNT;
  logic           oWR_FULL;
  logic           oWR_ALMOST_FULL;
  logic           oRD_EMPTY;
  logic           oRD_ALMOST_EMPTY;
  logic           oOVERFLOW;
  logic           oUNDERFLOW;
  logic [7:0]     oDROP_COUNT;

  modport master (
    output iREMOVE, iERR_CLEAR, iAF_THRESH, iAE_THRESH, iWR_EN, iWR_DATA, iRD_EN,
    input  oRD_DATA, oCOUNT, oWR_FULL, oWR_ALMOST_FULL, oRD_EMPTY, oRD_ALMOST_EMPTY,
           oOVERFLOW, oUNDERFLOW, oDROP_COUNT
  );

  modport slave (
    input  iREMOVE, iERR_CLEAR, iAF_THRESH, iAE_THRESH, iWR_EN, iWR_DATA, iRD_EN,
    output oRD_DATA, oCOUNT, oWR_FULL, oWR_ALMOST_FULL, oRD_EMPTY, oRD_ALMOST_EMPTY,
           oOVERFLOW, oUNDERFLOW, oDROP_COUNT
  );
endinterface

// File: rtl/keyboard_sync_fifo_flex.sv
// Single-clock show-ahead FIFO with occupancy count, run-time thresholds, selectable
// overflow policy, sticky error flags and a saturating dropped-entry counter.
module keyboard_sync_fifo_flex #(
  parameter int N         = 16,
  parameter int DEPTH     = 16,
  parameter int D_N       = 4,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic                    iCLOCK,
  input  logic                    inRESET,
  keyboard_sync_fifo_flex_if.slave bus
);

  localparam logic [D_N:0] DEPTH_C = (D_N+1)'(DEPTH);

  logic [N-1:0] mem_q [DEPTH];
  logic [D_N:0] wp_q, wp_d, rp_q, rp_d;
  logic         ovf_q, ovf_d, unf_q, unf_d;
  logic [7:0]   drop_q, drop_d;
  logic [D_N:0] count;
  logic         full, empty, mem_we, ovf_evt, unf_evt;

  assign count = wp_q - rp_q;
  assign full  = (count == DEPTH_C);
  assign empty = (count == '0);

  always_comb begin
    wp_d    = wp_q;
    rp_d    = rp_q;
    mem_we  = 1'b0;
    ovf_evt = 1'b0;
    unf_evt = 1'b0;
    if (bus.iREMOVE) begin
      wp_d = '0;
      rp_d = '0;
    end else begin
      if (bus.iRD_EN) begin
        if (!empty) rp_d = rp_q + 1'b1;
        else        unf_evt = 1'b1;
      end
      // A pop on a full FIFO frees the slot the concurrent write lands in.
      if (bus.iWR_EN) begin
        if (!full || bus.iRD_EN) begin
          mem_we = 1'b1;
          wp_d   = wp_q + 1'b1;
        end else begin
          ovf_evt = 1'b1;
          if (OVERWRITE) begin
            mem_we = 1'b1;
            wp_d   = wp_q + 1'b1;
            rp_d   = rp_q + 1'b1;
          end
        end
      end
    end
  end

  // A new error event outranks a simultaneous clear.
  always_comb begin
    ovf_d  = ovf_evt | (ovf_q & ~bus.iERR_CLEAR);
    unf_d  = unf_evt | (unf_q & ~bus.iERR_CLEAR);
    drop_d = bus.iERR_CLEAR ? 8'd0 : drop_q;
    if (ovf_evt && (drop_d != 8'hFF)) drop_d = drop_d + 8'd1;
  end

  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wp_q   <= '0;
      rp_q   <= '0;
      ovf_q  <= 1'b0;
      unf_q  <= 1'b0;
      drop_q <= 8'd0;
    end else begin
      wp_q   <= wp_d;
      rp_q   <= rp_d;
      ovf_q  <= ovf_d;
      unf_q  <= unf_d;
      drop_q <= drop_d;
    end
  end

  always_ff @(posedge iCLOCK) begin
    if (mem_we) mem_q[wp_q[D_N-1:0]] <= bus.iWR_DATA;
  end

  assign bus.oRD_DATA         = mem_q[rp_q[D_N-1:0]];
  assign bus.oCOUNT           = count;
  assign bus.oWR_FULL         = full;
  assign bus.oRD_EMPTY        = empty;
  assign bus.oWR_ALMOST_FULL  = (count >= bus.iAF_THRESH);
  assign bus.oRD_ALMOST_EMPTY = (count <= bus.iAE_THRESH);
  assign bus.oOVERFLOW        = ovf_q;
  assign bus.oUNDERFLOW       = unf_q;
  assign bus.oDROP_COUNT      = drop_q;

endmodule

// File: tb/tb_keyboard_sync_fifo_flex.sv
// Scoreboard bench: two FIFOs (drop-newest and overwrite-oldest) share one stimulus stream
// and are compared every cycle against a queue-based reference model.
module tb_keyboard_sync_fifo_flex;
  localparam int N = 8, DEPTH = 4, D_N = 2;

  logic iCLOCK = 1'b0;
  logic inRESET = 1'b0;
  always #5 iCLOCK = ~iCLOCK;

  logic       remove, clr, wr, rd;
  logic [7:0] wdata;
  logic [2:0] af_th, ae_th;

  keyboard_sync_fifo_flex_if #(.N(N), .D_N(D_N)) b0 ();
  keyboard_sync_fifo_flex_if #(.N(N), .D_N(D_N)) b1 ();

  assign b0.iREMOVE = remove;  assign b1.iREMOVE = remove;
  assign b0.iERR_CLEAR = clr;  assign b1.iERR_CLEAR = clr;
  assign b0.iAF_THRESH = af_th; assign b1.iAF_THRESH = af_th;
  assign b0.iAE_THRESH = ae_th; assign b1.iAE_THRESH = ae_th;
  assign b0.iWR_EN = wr;       assign b1.iWR_EN = wr;
  assign b0.iWR_DATA = wdata;  assign b1.iWR_DATA = wdata;
  assign b0.iRD_EN = rd;       assign b1.iRD_EN = rd;

  keyboard_sync_fifo_flex #(.N(N), .DEPTH(DEPTH), .D_N(D_N), .OVERWRITE(1'b0)) u0 (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .bus(b0));
  keyboard_sync_fifo_flex #(.N(N), .DEPTH(DEPTH), .D_N(D_N), .OVERWRITE(1'b1)) u1 (
    .iCLOCK(iCLOCK), .inRESET(inRESET), .bus(b1));

  typedef struct packed {
    logic [7:0] dat;
    logic [2:0] cnt;
    logic       empty, full, af, ae, ovf, unf;
    logic [7:0] drop;
  } obs_t;

  obs_t act [2];
  assign act[0] = {b0.oRD_DATA, b0.oCOUNT, b0.oRD_EMPTY, b0.oWR_FULL, b0.oWR_ALMOST_FULL,
                   b0.oRD_ALMOST_EMPTY, b0.oOVERFLOW, b0.oUNDERFLOW, b0.oDROP_COUNT};
  assign act[1] = {b1.oRD_DATA, b1.oCOUNT, b1.oRD_EMPTY, b1.oWR_FULL, b1.oWR_ALMOST_FULL,
                   b1.oRD_ALMOST_EMPTY, b1.oOVERFLOW, b1.oUNDERFLOW, b1.oDROP_COUNT};

  // Reference model: index 0 drops the newest on overflow, index 1 overwrites the oldest.
  logic [7:0] mq [2][$];
  bit         m_ovf [2];
  bit         m_unf [2];
  int         m_drop [2];
  obs_t       expq [2][$];

  int n_vec = 0;
  int n_bad = 0;

  task automatic chk(input string name, input int p, input int got, input int want);
    n_vec++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s[dut%0d] @%0t: got 0x%0h expected 0x%0h", name, p, $time, got, want);
    end
  endtask

  function automatic obs_t predict(input int p);
    obs_t e;
    int   c;
    c       = mq[p].size();
    e.cnt   = 3'(c);
    e.dat   = (c > 0) ? mq[p][0] : 8'h00;
    e.empty = (c == 0);
    e.full  = (c == DEPTH);
    e.af    = (c >= int'(af_th));
    e.ae    = (c <= int'(ae_th));
    e.ovf   = m_ovf[p];
    e.unf   = m_unf[p];
    e.drop  = 8'(m_drop[p]);
    return e;
  endfunction

  task automatic model_reset();
    for (int p = 0; p < 2; p++) begin
      mq[p].delete();
      m_ovf[p]  = 1'b0;
      m_unf[p]  = 1'b0;
      m_drop[p] = 0;
    end
  endtask

  task automatic model_edge();
    for (int p = 0; p < 2; p++) begin
      bit ovfe, unfe, was_empty, was_full;
      ovfe = 1'b0;
      unfe = 1'b0;
      was_empty = (mq[p].size() == 0);
      was_full  = (mq[p].size() == DEPTH);
      if (!remove) begin
        if (rd) begin
          if (!was_empty) void'(mq[p].pop_front());
          else unfe = 1'b1;
        end
        if (wr) begin
          if (!was_full || rd) mq[p].push_back(wdata);
          else begin
            ovfe = 1'b1;
            if (p == 1) begin
              void'(mq[p].pop_front());
              mq[p].push_back(wdata);
            end
          end
        end
      end else begin
        mq[p].delete();
      end
      if (clr) begin
        m_ovf[p]  = ovfe;
        m_unf[p]  = unfe;
        m_drop[p] = ovfe ? 1 : 0;
      end else begin
        m_ovf[p] = m_ovf[p] | ovfe;
        m_unf[p] = m_unf[p] | unfe;
        if (ovfe && m_drop[p] < 255) m_drop[p]++;
      end
    end
  endtask

  task automatic check_one(input int p);
    obs_t e, a;
    e = expq[p].pop_front();
    a = act[p];
    chk("count", p, int'(a.cnt), int'(e.cnt));
    chk("empty", p, int'(a.empty), int'(e.empty));
    chk("full", p, int'(a.full), int'(e.full));
    chk("almost_full", p, int'(a.af), int'(e.af));
    chk("almost_empty", p, int'(a.ae), int'(e.ae));
    chk("overflow", p, int'(a.ovf), int'(e.ovf));
    chk("underflow", p, int'(a.unf), int'(e.unf));
    chk("drop_count", p, int'(a.drop), int'(e.drop));
    if (!e.empty) chk("rd_data", p, int'(a.dat), int'(e.dat));
  endtask

  always @(negedge iCLOCK) begin
    for (int p = 0; p < 2; p++)
      if (expq[p].size() > 0) check_one(p);
  end

  task automatic step(input bit w, input bit r, input logic [7:0] d,
                      input bit rm = 1'b0, input bit cl = 1'b0);
    wr = w; rd = r; wdata = d; remove = rm; clr = cl;
    @(posedge iCLOCK);
    model_edge();
    for (int p = 0; p < 2; p++) expq[p].push_back(predict(p));
    @(negedge iCLOCK);
    #1;
    wr = 1'b0; rd = 1'b0; remove = 1'b0; clr = 1'b0;
  endtask

  initial begin
    logic [7:0] seq [4];
    seq[0] = 8'h11; seq[1] = 8'h22; seq[2] = 8'h33; seq[3] = 8'h44;
    wr = 1'b0; rd = 1'b0; remove = 1'b0; clr = 1'b0; wdata = 8'h00;
    af_th = 3'd3; ae_th = 3'd1;
    model_reset();

    repeat (2) @(posedge iCLOCK);
    for (int p = 0; p < 2; p++) expq[p].push_back(predict(p));
    @(negedge iCLOCK);
    #1 inRESET = 1'b1;

    // Fill, overflow under both policies, drain past empty.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, seq[i]);
    step(1'b1, 1'b0, 8'h55);
    repeat (5) step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    // Drop counter saturation.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, seq[i]);
    repeat (300) step(1'b1, 1'b0, 8'($urandom));
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    repeat (4) step(1'b0, 1'b1, 8'h00);

    // Simultaneous write+pop on empty, then on full.
    step(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, seq[i]);
    step(1'b1, 1'b1, 8'h66);

    // Flush with an overflow pending, then clear errors.
    step(1'b1, 1'b0, 8'h77);
    step(1'b0, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h88, 1'b1, 1'b0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);

    repeat (2000) begin
      af_th = 3'($urandom_range(0, 7));
      ae_th = 3'($urandom_range(0, 7));
      step(($urandom_range(0, 99) < 60), ($urandom_range(0, 99) < 50), 8'($urandom),
           ($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 3));
    end

    // Asynchronous reset between edges, with data and a flag present.
    af_th = 3'd3; ae_th = 3'd1;
    repeat (5) step(1'b1, 1'b0, 8'($urandom));
    #1 inRESET = 1'b0;
    #1;
    chk("async_rst_count", 0, int'(b0.oCOUNT), 0);
    chk("async_rst_count", 1, int'(b1.oCOUNT), 0);
    chk("async_rst_overflow", 0, int'(b0.oOVERFLOW), 0);
    chk("async_rst_drop", 1, int'(b1.oDROP_COUNT), 0);
    model_reset();
    #1 inRESET = 1'b1;
    step(1'b1, 1'b0, 8'h3C);
    step(1'b0, 1'b1, 8'h00);
    step(1'b0, 1'b0, 8'h00);

    chk("scoreboard_drained", 0, expq[0].size(), 0);
    chk("scoreboard_drained", 1, expq[1].size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/keyboard_sync_fifo_flex.md
# keyboard_sync_fifo_flex

Parametrised single-clock show-ahead FIFO, successor to the keyboard scan-code FIFO, for all device-side receive paths (keyboard, serial, timer event queues). Adds full-range occupancy count, run-time almost-full/almost-empty thresholds, and selectable overflow policy (drop-newest or overwrite-oldest). Adds sticky overflow/underflow error flags and a saturating dropped-entry counter, readable by the device register block.

## Interface
- N, 16, data width in bits
- DEPTH, 16, entry count; power of two, ≥ 2
- D_N, 4, log2(DEPTH)
- OVERWRITE, 0, 0 = write to full FIFO is discarded; 1 = write to full FIFO replaces the oldest entry

- iCLOCK  in  1  clock; all state changes on rising edge
- inRESET  in  1  reset, asynchronous, active-low
- iREMOVE  in  1  synchronous flush
- iERR_CLEAR  in  1  synchronous clear of oOVERFLOW, oUNDERFLOW, oDROP_COUNT
- iAF_THRESH  in  D_N+1  almost-full threshold, 0..DEPTH
- iAE_THRESH  in  D_N+1  almost-empty threshold, 0..DEPTH
- iWR_EN  in  1  write request
- iWR_DATA  in  N  write data
- iRD_EN  in  1  pop request
- oRD_DATA  out  N  head entry (show-ahead)
- oCOUNT  out  D_N+1  occupancy, 0..DEPTH
- oWR_FULL  out  1  count == DEPTH
- oWR_ALMOST_FULL  out  1  count ≥ iAF_THRESH
- oRD_EMPTY  out  1  count == 0
- oRD_ALMOST_EMPTY  out  1  count ≤ iAE_THRESH
- oOVERFLOW  out  1  sticky: a write hit a full FIFO
- oUNDERFLOW  out  1  sticky: a pop hit an empty FIFO
- oDROP_COUNT  out  8  saturating count of lost entries

## Operation
- State: write pointer wp and read pointer rp, each D_N+1 bits, wrapping modulo 2·DEPTH; memory addressed by low D_N bits; count = wp − rp (D_N+1 bits, modulo).
- Memory is not reset; oRD_DATA = mem[rp[D_N-1:0]], don't-care while oRD_EMPTY.
- Priority per edge: inRESET > iREMOVE > WR/RD > iERR_CLEAR for the error state.
- Write, not full: mem[wp] ← iWR_DATA, wp+1.
- Pop, not empty: rp+1.
- Write + pop, full: both execute; count stays DEPTH; no overflow.
- Write + pop, empty: write executes; pop ignored; oUNDERFLOW set.
- Write, full, no pop, OVERWRITE=0: data discarded; pointers hold; oOVERFLOW set; oDROP_COUNT+1.
- Write, full, no pop, OVERWRITE=1: mem[wp] ← data, wp+1, rp+1; count stays DEPTH; oldest entry lost; oOVERFLOW set; oDROP_COUNT+1.
- Pop, empty, no write: ignored; oUNDERFLOW set.
- oDROP_COUNT saturates at 255; it never wraps.
- iREMOVE: wp = rp = 0; in-flight WR/RD that cycle ignored; no error flag set; flags and oDROP_COUNT retained.
- iERR_CLEAR: clears oOVERFLOW, oUNDERFLOW, oDROP_COUNT. If an error event occurs in the same cycle, the new event wins: flag = 1, oDROP_COUNT = 1 for overflow.
- Thresholds are used combinationally. Values > DEPTH are legal: AF never asserts; AE always asserts.

## Timing
- Reset values: oCOUNT=0, oRD_EMPTY=1, oRD_ALMOST_EMPTY=1 (count 0 ≤ any threshold), oWR_FULL=0, oOVERFLOW=0, oUNDERFLOW=0, oDROP_COUNT=0. oWR_ALMOST_FULL=1 only if iAF_THRESH=0.
- Write-to-read latency is 1 cycle: data written at edge k appears on oRD_DATA and deasserts oRD_EMPTY after edge k.
- Pop at edge k: next entry is on oRD_DATA after edge k.
- All status outputs derive combinationally from registered pointers/flags: they change only after a clock edge, or immediately on a threshold input change.
- Asynchronous reset mid-burst takes effect immediately; the first operation is accepted at the first edge after inRESET rises.

## Test plan
- N=8, DEPTH=4: reset; write 0x11,0x22,0x33,0x44 -> oCOUNT=4, oWR_FULL=1, oRD_DATA=0x11; 4 pops return 0x11..0x44, then oRD_EMPTY=1.
- OVERWRITE=0, full {0x11..0x44}: write 0x55 -> contents unchanged, oOVERFLOW=1, oDROP_COUNT=1; 300 more full-writes -> oDROP_COUNT=255.
- OVERWRITE=1, full {0x11..0x44}: write 0x55 -> oCOUNT=4, oRD_DATA=0x22; drain yields 0x22,0x33,0x44,0x55.
- Empty: write 0xA5 + pop same edge -> oCOUNT=1, oRD_DATA=0xA5, oUNDERFLOW=1. Full: write + pop -> oCOUNT=4, oOVERFLOW=0.
- iAF_THRESH=3, iAE_THRESH=1: fill 0→4 -> AE=1 at counts 0,1; AF=1 at counts 3,4.
- Count=3 with oOVERFLOW=1: assert iREMOVE + iWR_EN -> oCOUNT=0, oRD_EMPTY=1, oOVERFLOW stays 1. Then iERR_CLEAR -> flags 0, oDROP_COUNT=0.
